mio_uart_tx: RTL

//  Memory-mapped UART transmitter; responder on the MIO bus for CPU store cycles.
//  CPU writes bytes via MIO_BUS (Peripheral_in + decoded write strobe); block buffers them in a FIFO and serialises 8N1 on tx.

---
 rtl/mio_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/mio_uart_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// Shared MIO bus definitions: UART register offsets, status/ctrl bit positions and TX FSM states.
package mio_pkg;

  localparam logic [3:0] MIO_UART_DATA_OFS = 4'h0;
  localparam logic [3:0] MIO_UART_CTRL_OFS = 4'h4;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EN      = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_EN      = 1;
  localparam int CTRL_OVF_CLR = 2;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; flush has priority over push and pop.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mio_uart_tx.sv
// MIO-mapped UART transmitter: DATA/CTRL register decode, TX FIFO, baud-timed 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module mio_uart_tx
  import mio_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        uart_we,
  input  logic        addr_sel,
  input  logic [31:0] wdata,
  output logic [31:0] status_out,
  output logic        busy,
  output logic        tx
);

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int BAUD_W = $clog2(DIV);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              bit_end;
  logic              pop;
  logic              en;
  logic              ovf;
  logic              wr_data;
  logic              wr_ctrl;
  logic              flush;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [8:0]        cnt_ext;
  logic              unused_bits;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign wr_data = uart_we && (addr_sel == MIO_UART_DATA_OFS[2]);
  assign wr_ctrl = uart_we && (addr_sel == MIO_UART_CTRL_OFS[2]);
  assign flush   = wr_ctrl && wdata[CTRL_FLUSH];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rst_n (RSTN),
    .push  (wr_data),
    .pop   (pop),
    .flush (flush),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A DATA write that finds the FIFO full is dropped inside the FIFO; here it only latches ovf.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      en  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (wr_data && fifo_full) ovf <= 1'b1;
      if (wr_ctrl) begin
        en <= wdata[CTRL_EN];
        if (wdata[CTRL_OVF_CLR]) ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state <= UART_IDLE;
    else       state <= state_nxt;
  end

  assign bit_end = (baud_cnt == BAUD_W'(DIV - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      UART_IDLE: begin
        if (en && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = UART_START;
        end
      end
      UART_START: if (bit_end) state_nxt = UART_DATA;
      UART_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = UART_PARITY;
`else
          state_nxt = UART_STOP;
`endif
        end
      end
      UART_PARITY: if (bit_end) state_nxt = UART_STOP;
      UART_STOP: begin
        if (bit_end) begin
          if (en && !fifo_empty) begin
            pop       = 1'b1;
            state_nxt = UART_START;
          end else begin
            state_nxt = UART_IDLE;
          end
        end
      end
      default: state_nxt = UART_IDLE;
    endcase
  end

  // Baud counter restarts on every state entry; transitions only happen on bit_end or from IDLE.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if (state == UART_IDLE || bit_end) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + BAUD_W'(1);
      if (pop)                                  bit_idx <= '0;
      else if (state == UART_DATA && bit_end)   bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
      par   <= ^fifo_dout;
`endif
    end else if (state == UART_DATA && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state)
      UART_START:  tx = 1'b0;
      UART_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
      UART_PARITY: tx = par;
`endif
      default:     tx = 1'b1;
    endcase
  end

  assign busy    = (state != UART_IDLE);
  assign cnt_ext = 9'(fifo_count);

  always_comb begin
    status_out                       = '0;
    status_out[ST_CNT_LSB +: 8]      = cnt_ext[7:0];
    status_out[ST_OVF]               = ovf;
    status_out[ST_EN]                = en;
    status_out[ST_FULL]              = fifo_full;
    status_out[ST_EMPTY]             = fifo_empty;
  end

  assign unused_bits = &{1'b0, wdata[31:8], cnt_ext[8]};

endmodule
